interp2_linear_split: RTL and testbench



---
 rtl/interp2_linear_split_if.sv | 19 +
 rtl/interp2_linear_split.sv | 87 ++++++++
 tb/tb_interp2_linear_split.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/interp2_linear_split_if.sv
// interp2_linear_split_if: input and output AXI-Stream sample channels of the 2x interpolator
interface interp2_linear_split_if #(parameter int WIDTH = 16);
    logic [2*WIDTH-1:0] i_tdata;
    logic               i_tlast;
    logic               i_tvalid;
    logic               i_tready;
    logic [2*WIDTH-1:0] o_tdata;
    logic               o_tlast;
    logic               o_tvalid;
    logic               o_tready;
    modport slave (
        input  i_tdata, i_tlast, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tlast, o_tvalid
    );
    modport master (
        output i_tdata, i_tlast, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tlast, o_tvalid
    );
endinterface

// File: rtl/interp2_linear_split.sv
// interp2_linear_split: 2x linear interpolator, emits midpoint(prev,cur) then cur per input sample
module interp2_linear_split #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    interp2_linear_split_if.slave  bus
);
    localparam int DW = 2 * WIDTH;

    typedef enum logic [1:0] {S_EMPTY, S_MID, S_SAMP} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   cur_q, cur_d;
    logic [DW-1:0]   prev_q, prev_d;
    logic [DW-1:0]   data_q, data_d;
    logic            last_q, last_d;
    logic            olast_q, olast_d;
    logic            valid_q, valid_d;
    logic            accept;

    // Sum in WIDTH+1 bits so it never overflows; halving rounds toward zero.
    function automatic logic [WIDTH-1:0] mid(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        return s[WIDTH:1] + {{(WIDTH-1){1'b0}}, s[WIDTH] & s[0]};
    endfunction

    assign bus.i_tready = !(reset || clear) &&
                          (state_q == S_EMPTY || (state_q == S_SAMP && bus.o_tready));
    assign accept       = bus.i_tvalid && bus.i_tready;
    assign bus.o_tdata  = data_q;
    assign bus.o_tlast  = olast_q;
    assign bus.o_tvalid = valid_q;

    // Next state: advance MID->SAMP->EMPTY on downstream ready; a new input overrides to MID.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        prev_d  = prev_q;
        data_d  = data_q;
        last_d  = last_q;
        olast_d = olast_q;
        valid_d = valid_q;
        if (state_q == S_MID && bus.o_tready) begin
            data_d  = cur_q;
            olast_d = last_q;
            state_d = S_SAMP;
            prev_d  = last_q ? '0 : cur_q;
        end
        if (state_q == S_SAMP && bus.o_tready) begin
            valid_d = 1'b0;
            state_d = S_EMPTY;
        end
        if (accept) begin
            cur_d   = bus.i_tdata;
            last_d  = bus.i_tlast;
            data_d  = {mid(prev_q[DW-1:WIDTH], bus.i_tdata[DW-1:WIDTH]),
                       mid(prev_q[WIDTH-1:0], bus.i_tdata[WIDTH-1:0])};
            olast_d = 1'b0;
            valid_d = 1'b1;
            state_d = S_MID;
        end
    end

    // State registers; reset and soft clear both drop pending output and zero history.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q <= S_EMPTY;
            cur_q   <= '0;
            prev_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            olast_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            prev_q  <= prev_d;
            data_q  <= data_d;
            last_q  <= last_d;
            olast_q <= olast_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_interp2_linear_split.sv
// tb_interp2_linear_split: scoreboard bench with a reference interpolator model
module tb_interp2_linear_split;
    localparam int W = 16;

    typedef struct {
        logic [2*W-1:0] data;
        logic           last;
        bit             second;
    } exp_t;

    logic clk = 0;
    logic reset;
    logic clear;
    interp2_linear_split_if #(.WIDTH(W)) bus ();

    interp2_linear_split #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   pops = 0;
    int   last_pop_cyc = 0;
    int   hist_i = 0;
    int   hist_q = 0;
    bit   rdy_rand = 0;
    bit   rdy_val = 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2*W-1:0] pk(input int i, input int q);
        return {i[W-1:0], q[W-1:0]};
    endfunction

    function automatic int midv(input int a, input int b);
        return (a + b) / 2;
    endfunction

    // Reference model: every accepted sample yields its midpoint with history, then itself.
    task automatic model_push(input int i, input int q, input bit last);
        sb.push_back('{pk(midv(hist_i, i), midv(hist_q, q)), 1'b0, 1'b0});
        sb.push_back('{pk(i, q), last, 1'b1});
        hist_i = last ? 0 : i;
        hist_q = last ? 0 : q;
    endtask

    task automatic send(input int i, input int q, input bit last);
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = pk(i, q);
        bus.i_tlast  = last;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (bus.i_tready) break;
            if (n > 2000) begin
                $display("FAIL send_timeout sample not accepted");
                $fatal(1, "input stalled");
            end
        end
        model_push(i, q, last);
        @(posedge clk);
        #1;
        bus.i_tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; ; n++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !bus.o_tvalid) break;
            if (n > 5000) begin
                chk(1'b0, "drain_timeout", 64'(sb.size()), 64'd0);
                break;
            end
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        sb.delete();
        hist_i = 0;
        hist_q = 0;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    // Cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream ready generator
    initial begin
        bus.o_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.o_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    // Monitor: AXI hold rule, i_tready expectation, and scoreboard comparison
    initial begin
        logic [2*W-1:0] p_data;
        bit p_valid, p_ready, p_last, p_rst;
        bit exp_rdy;
        exp_t e;
        p_valid = 0; p_ready = 0; p_last = 0; p_rst = 1; p_data = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (p_valid && !p_ready && !p_rst)
                    chk(bus.o_tvalid && bus.o_tdata == p_data && bus.o_tlast == p_last,
                        "hold_stable", {bus.o_tvalid, bus.o_tlast, bus.o_tdata}, {1'b1, p_last, p_data});
                exp_rdy = !clear && (!bus.o_tvalid || (bus.o_tready && sb.size() > 0 && sb[0].second));
                chk(bus.i_tready == exp_rdy, "i_tready", 64'(bus.i_tready), 64'(exp_rdy));
                if (bus.o_tvalid && bus.o_tready && !clear) begin
                    if (sb.size() == 0) begin
                        chk(1'b0, "unexpected_output", 64'(bus.o_tdata), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk(bus.o_tdata == e.data && bus.o_tlast == e.last, "out_data",
                            {bus.o_tlast, bus.o_tdata}, {e.last, e.data});
                    end
                    pops++;
                    last_pop_cyc = cyc;
                end
            end
            p_valid = bus.o_tvalid;
            p_ready = bus.o_tready;
            p_data  = bus.o_tdata;
            p_last  = bus.o_tlast;
            p_rst   = reset || clear;
        end
    end

    // Main stimulus sequence
    initial begin
        int c0, p0, gi, gq;
        reset = 1'b1;
        clear = 1'b0;
        bus.i_tvalid = 1'b0;
        bus.i_tdata  = '0;
        bus.i_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(bus.o_tvalid == 1'b0, "rst_valid", 64'(bus.o_tvalid), 64'd0);
        chk(bus.o_tdata == '0, "rst_data", 64'(bus.o_tdata), 64'd0);
        chk(bus.o_tlast == 1'b0, "rst_last", 64'(bus.o_tlast), 64'd0);
        chk(bus.i_tready == 1'b0, "rst_ready", 64'(bus.i_tready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic pair, back-to-back with no bubble
        c0 = cyc;
        p0 = pops;
        send(100, -3, 0);
        send(201, -6, 0);
        for (int n = 0; pops < p0 + 4; n++) begin
            @(posedge clk);
            if (n > 100) begin
                chk(1'b0, "case1_timeout", 64'(pops), 64'(p0 + 4));
                break;
            end
        end
        chk(last_pop_cyc == c0 + 4, "no_bubble", 64'(last_pop_cyc - c0), 64'd4);
        drain();
        pulse_clear();

        // Extremes
        send(32767, -32768, 0);
        send(32767, -32768, 0);
        drain();
        pulse_clear();

        // Packet boundary resets history
        send(10, 10, 1);
        send(20, 20, 0);
        drain();
        pulse_clear();

        // Backpressure: output held, no input consumed
        rdy_val = 1'b0;
        @(posedge clk);
        #1;
        send(100, -3, 0);
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = pk(201, -6);
        bus.i_tlast  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk(bus.i_tready == 1'b0, "bp_ready", 64'(bus.i_tready), 64'd0);
            chk(bus.o_tvalid == 1'b1, "bp_valid", 64'(bus.o_tvalid), 64'd1);
        end
        rdy_val = 1'b1;
        send(201, -6, 0);
        drain();

        // Clear while the midpoint is presented
        rdy_val = 1'b0;
        @(posedge clk);
        #1;
        send(50, 50, 0);
        pulse_clear();
        @(negedge clk);
        chk(bus.o_tvalid == 1'b0, "clear_valid", 64'(bus.o_tvalid), 64'd0);
        rdy_val = 1'b1;
        @(posedge clk);
        #1;
        send(8, 8, 0);
        drain();

        // Randomized traffic with random backpressure
        rdy_rand = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            gi = int'($urandom_range(0, 65535)) - 32768;
            gq = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 7) == 0) gi = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
            send(gi, gq, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
        end
        drain();
        chk(sb.size() == 0, "sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
